// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Generates the core reset for everything clocked from the PLL output.
// Sequence:
//   1. Wait for the synchronised lock flag.
//   2. Require a run of stable locked cycles.
//   3. Hold the core in reset for a fixed time.
//   4. Release the reset synchronously.
// In RUN the block watches for lock loss. Dropouts shorter than
// UNLOCK_FILTER cycles are ignored. A software request re-runs the hold
// phase without requalifying lock.
//
// Ports:
//   CLK        in   PLL output clock; the only clock of this block
//   resetn     in   asynchronous active-low reset
//   locked     in   PLL lock flag, asynchronous to CLK
//   sw_rst_req in   one-cycle request to re-run the hold phase (RUN only)
//   rst_out_n  out  core reset, active-low
//                   asserts asynchronously with resetn, deasserts on CLK
//   ready      out  high only in RUN
//   lock_lost  out  one-cycle pulse per filtered lock loss
//   state      out  0=WAIT_LOCK 1=SETTLE 2=HOLD 3=RUN
//   loss_count out  number of lock-loss events, saturating at 255
//
// Optional feature macro: PLL_LOSS_COUNTER_EN
//   When defined, loss_count counts lock_lost pulses.
//   When undefined, loss_count is tied to zero and no counter flops exist.
//
// Handshake: there is no valid/ready pair on this block. The output
// "ready" is a level status that is high exactly while state==RUN. No
// transfer is qualified by it.
module pll_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned UNLOCK_FILTER      = 4,
  parameter int unsigned CNT_W              = 16
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       locked,
  input  logic       sw_rst_req,
  output logic       rst_out_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [1:0] state,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts. Each one forces a state change, so the counter never wraps.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(UNLOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             lk_s;   // synchronised lock flag; the only use of locked

`ifdef PLL_LOSS_COUNTER_EN
  logic [7:0] loss_q;
  assign loss_count = loss_q;
`else
  assign loss_count = 8'd0;
`endif

  assign state = st;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      st        <= WAIT_LOCK;
      cnt       <= '0;
      sync1     <= 1'b0;
      lk_s      <= 1'b0;
      rst_out_n <= 1'b0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
`ifdef PLL_LOSS_COUNTER_EN
      loss_q    <= 8'd0;
`endif
    end else begin
      sync1     <= locked;
      lk_s      <= sync1;
      lock_lost <= 1'b0;
      case (st)
        WAIT_LOCK: begin
          cnt       <= '0;
          rst_out_n <= 1'b0;
          ready     <= 1'b0;
          if (lk_s) st <= SETTLE;
        end
        SETTLE: begin
          if (!lk_s) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == LOCK_LAST) begin
            st  <= HOLD;
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (!lk_s) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            // Reset release and ready are registered on the same edge.
            st        <= RUN;
            cnt       <= '0;
            rst_out_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!lk_s && (cnt == FILT_LAST)) begin
            // A real lock loss takes priority over a coincident sw_rst_req.
            st        <= WAIT_LOCK;
            cnt       <= '0;
            rst_out_n <= 1'b0;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
`ifdef PLL_LOSS_COUNTER_EN
            if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
`endif
          end else if (sw_rst_req) begin
            st        <= HOLD;
            cnt       <= '0;
            rst_out_n <= 1'b0;
            ready     <= 1'b0;
          end else if (lk_s) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          st  <= WAIT_LOCK;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer.
// Configuration: LOCK_STABLE=8, HOLD=4, FILTER=3.
// Each stimulus step pushes the output changes it expects onto exp_q.
// Each entry holds: edge number, state, rst_out_n, ready, lock_lost and
// loss_count. A monitor samples on the falling edge. Whenever the output
// tuple changes, it pops one entry and compares against it.
module tb_pll_reset_sequencer;

  localparam int W = 45;   // 32-bit edge stamp + 13-bit output tuple

  logic       CLK;
  logic       resetn;
  logic       locked;
  logic       sw_rst_req;
  logic       rst_out_n;
  logic       ready;
  logic       lock_lost;
  logic [1:0] state;
  logic [7:0] loss_count;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           edge_n = 0;
  int           losses = 0;
  logic         mon_en = 1'b0;
  logic [12:0]  prev   = '0;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .RESET_HOLD_CYCLES (4),
    .UNLOCK_FILTER     (3),
    .CNT_W             (16)
  ) dut (
    .CLK       (CLK),
    .resetn    (resetn),
    .locked    (locked),
    .sw_rst_req(sw_rst_req),
    .rst_out_n (rst_out_n),
    .ready     (ready),
    .lock_lost (lock_lost),
    .state     (state),
    .loss_count(loss_count)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_n <= edge_n + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- model helpers ----------------
  function automatic int exp_lc(input int n);
`ifdef PLL_LOSS_COUNTER_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  function automatic void push(input logic [31:0] e, input logic [1:0] st, input logic r,
                               input logic rd, input logic ll, input int lc);
    logic [7:0] lc8;
    lc8 = lc[7:0];
    exp_q.push_back({e, st, r, rd, ll, lc8});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // From WAIT_LOCK with the synchroniser flushed to 0: lock and reach RUN.
  task automatic lock_up();
    int e;
    e = edge_n;
    locked = 1'b1;
    push(e + 3,  2'd1, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    push(e + 11, 2'd2, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    push(e + 15, 2'd3, 1'b1, 1'b1, 1'b0, exp_lc(losses));
    tick(15);
  endtask

  // From RUN: drop lock for good; the filter expires on the 3rd unlocked sample.
  task automatic lose_lock(input logic with_sw);
    int f;
    f = edge_n;
    locked = 1'b0;
    losses++;
    push(f + 5, 2'd0, 1'b0, 1'b0, 1'b1, exp_lc(losses));
    push(f + 6, 2'd0, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    tick(4);
    sw_rst_req = with_sw;
    tick(1);
    sw_rst_req = 1'b0;
    tick(1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    logic [12:0]  cur;
    logic [W-1:0] e;
    cur = {state, rst_out_n, ready, lock_lost, loss_count};
    if (mon_en && (cur != prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: edge=%0d st=%0d rst=%0b rdy=%0b ll=%0b lc=%0d, none expected",
                 edge_n, cur[12:11], cur[10], cur[9], cur[8], cur[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (e != {edge_n[31:0], cur}) begin
          errors++;
          $display("FAIL event: got edge=%0d st=%0d rst=%0b rdy=%0b ll=%0b lc=%0d expected edge=%0d st=%0d rst=%0b rdy=%0b ll=%0b lc=%0d",
                   edge_n, cur[12:11], cur[10], cur[9], cur[8], cur[7:0],
                   e[44:13], e[12:11], e[10], e[9], e[8], e[7:0]);
        end
      end
    end
    prev = cur;
  end

  // ---------------- stimulus ----------------
  initial begin
    int e;
    int g;
    int r;
    resetn     = 1'b0;
    locked     = 1'b0;
    sw_rst_req = 1'b0;
    tick(2);
    check("reset_state",    int'(state),      0);
    check("reset_rst_out",  int'(rst_out_n),  0);
    check("reset_ready",    int'(ready),      0);
    check("reset_lock_lost",int'(lock_lost),  0);
    check("reset_loss_cnt", int'(loss_count), 0);
    mon_en = 1'b1;

    // Basic bring-up: reset release and locked=1 together, rst_out_n on edge 15.
    resetn = 1'b1;
    lock_up();

    // Two-cycle dropout in RUN is filtered: no output change expected.
    g = edge_n;
    locked = 1'b0;
    tick(2);
    locked = 1'b1;
    tick(4);
    check("glitch_edges", edge_n - g, 6);

    // Real lock loss.
    lose_lock(1'b0);
    tick(2);

    // Dropout during SETTLE at count 5: return to WAIT_LOCK, redo full settle.
    e = edge_n;
    locked = 1'b1;
    push(e + 3,  2'd1, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    push(e + 9,  2'd0, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    push(e + 10, 2'd1, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    push(e + 18, 2'd2, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    push(e + 22, 2'd3, 1'b1, 1'b1, 1'b0, exp_lc(losses));
    tick(6);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(15);

    // Software reset request: HOLD for exactly 4 cycles, no lock_lost.
    e = edge_n;
    sw_rst_req = 1'b1;
    push(e + 1, 2'd2, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    push(e + 5, 2'd3, 1'b1, 1'b1, 1'b0, exp_lc(losses));
    tick(1);
    sw_rst_req = 1'b0;
    tick(6);

    // sw_rst_req coincident with the third unlocked cycle: lock loss wins.
    lose_lock(1'b1);
    tick(2);

    // sw_rst_req outside RUN is ignored.
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(4);

    // Async reset in mid-HOLD, then a full restart.
    e = edge_n;
    locked = 1'b1;
    push(e + 3,  2'd1, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    push(e + 11, 2'd2, 1'b0, 1'b0, 1'b0, exp_lc(losses));
    tick(13);
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    check("async_state",    int'(state),      0);
    check("async_rst_out",  int'(rst_out_n),  0);
    check("async_ready",    int'(ready),      0);
    check("async_loss_cnt", int'(loss_count), 0);
    tick(3);
    losses = 0;
    mon_en = 1'b1;
    r = edge_n;
    resetn = 1'b1;
    push(r + 3,  2'd1, 1'b0, 1'b0, 1'b0, 0);
    push(r + 11, 2'd2, 1'b0, 1'b0, 1'b0, 0);
    push(r + 15, 2'd3, 1'b1, 1'b1, 1'b0, 0);
    tick(15);

    // 300 loss events: loss_count saturates at 255 when the counter is built.
    for (int i = 0; i < 300; i++) begin
      lose_lock(1'b0);
      lock_up();
    end
    check("loss_count_sat", int'(loss_count), exp_lc(300));

    tick(5);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
